// File: rtl/counter_bcd2bin_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_bcd2bin_pkg
//  Description : Shared types and constants for the sequential BCD-to-binary
//                converter (reverse double-dabble).
//                  - state_t            : converter FSM states
//                  - C_N_DIG_DEFAULT    : default number of BCD digits
//                  - C_W_BIN_DEFAULT    : default binary width / shift count
//                  - C_CORR_THRESH/SUB  : per-digit "if >= 8 subtract 3"
//                  - C_BCD_MAX_DIGIT    : largest legal BCD digit
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_bcd2bin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int         C_N_DIG_DEFAULT = 3;
    localparam int         C_W_BIN_DEFAULT = 10;

    localparam logic [3:0] C_CORR_THRESH   = 4'd8;
    localparam logic [3:0] C_CORR_SUB      = 4'd3;
    localparam logic [3:0] C_BCD_MAX_DIGIT = 4'd9;

    // True when a 4-bit nibble is not a legal BCD digit.
    function automatic logic digit_is_invalid(input logic [3:0] digit);
        return (digit > C_BCD_MAX_DIGIT);
    endfunction

endpackage : counter_bcd2bin_pkg
`default_nettype wire

// File: rtl/counter_bcd2bin_if.sv
`default_nettype none
// ============================================================================
//  Module      : counter_bcd2bin_if
//  Description : Request/response bundle of the BCD-to-binary converter.
//                  i_valid/o_ready/i_bcd : request side (packed BCD in)
//                  o_valid/i_ready/o_bin/o_err : response side
//                Modport slave is the converter, master is the user.
//  Revision    : 1.0 - initial release
// ============================================================================
interface counter_bcd2bin_if
    import counter_bcd2bin_pkg::*;
#(
    parameter int N_DIG = C_N_DIG_DEFAULT,
    parameter int W_BIN = C_W_BIN_DEFAULT
);
    logic               i_valid;
    logic               o_ready;
    logic [4*N_DIG-1:0] i_bcd;
    logic               o_valid;
    logic               i_ready;
    logic [W_BIN-1:0]   o_bin;
    logic               o_err;

    modport slave (
        input  i_valid, i_bcd, i_ready,
        output o_ready, o_valid, o_bin, o_err
    );

    modport master (
        output i_valid, i_bcd, i_ready,
        input  o_ready, o_valid, o_bin, o_err
    );
endinterface : counter_bcd2bin_if
`default_nettype wire

// File: rtl/counter_bcd_digit_corr.sv
`default_nettype none
// ============================================================================
//  Module      : counter_bcd_digit_corr
//  Description : Combinational per-digit correction for reverse double-dabble:
//                o_digit = (i_digit >= 8) ? i_digit - 3 : i_digit.
//                  i_digit : 4-bit digit after the right shift
//                  o_digit : corrected digit
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_bcd_digit_corr
    import counter_bcd2bin_pkg::*;
(
    input  wire logic [3:0] i_digit,
    output logic      [3:0] o_digit
);
    // Legal inputs never exceed 12 here, so the subtraction cannot wrap.
    assign o_digit = (i_digit >= C_CORR_THRESH) ? (i_digit - C_CORR_SUB) : i_digit;
endmodule : counter_bcd_digit_corr
`default_nettype wire

// File: rtl/counter_bcd2bin.sv
`default_nettype none
// ============================================================================
//  Module      : counter_bcd2bin
//  Description : Sequential BCD-to-binary converter using reverse
//                double-dabble: one right shift of {bcd, bin} per cycle,
//                then "subtract 3 from every digit >= 8". The result is
//                presented W_BIN edges after the accepting edge.
//  Ports       : i_clk   - clock, rising edge
//                i_rst_n - asynchronous active-low reset
//                bus     - counter_bcd2bin_if.slave (valid/ready in and out)
//  Options     : `define COUNTER_BCD2BIN_ERR_EN to flag input digits > 9 on
//                o_err; otherwise o_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_bcd2bin
    import counter_bcd2bin_pkg::*;
#(
    parameter int N_DIG = C_N_DIG_DEFAULT,
    parameter int W_BIN = C_W_BIN_DEFAULT
)(
    input  wire logic         i_clk,
    input  wire logic         i_rst_n,
    counter_bcd2bin_if.slave  bus
);
    localparam int BCD_W = 4 * N_DIG;
    localparam int CNT_W = $clog2(W_BIN + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [BCD_W-1:0]   r_bcd;
    logic [W_BIN-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_err;

    logic               w_ready;
    logic               w_valid;
    logic               w_accept;
    logic               w_last;
    logic [BCD_W+W_BIN-1:0] w_shift;
    logic [BCD_W-1:0]   w_bcd_corr;

    assign w_accept = bus.i_valid && (r_state == ST_IDLE);
    assign w_last   = (r_cnt == CNT_W'(W_BIN - 1));

    // The BCD LSB falls into the binary MSB on every shift.
    assign w_shift  = {r_bcd, r_bin} >> 1;

    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_digit
            counter_bcd_digit_corr u_corr (
                .i_digit (w_shift[W_BIN + 4*gi +: 4]),
                .o_digit (w_bcd_corr[4*gi +: 4])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.i_valid) begin
                    w_state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_valid = 1'b1;
                if (bus.i_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift registers and iteration counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bcd <= '0;
            r_bin <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_bcd <= bus.i_bcd;
            r_bin <= '0;
            r_cnt <= '0;
        end else if (r_state == ST_CONV) begin
            r_bcd <= w_bcd_corr;
            r_bin <= w_shift[W_BIN-1:0];
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Optional illegal-digit flag, captured with the request
    // ------------------------------------------------------------------
`ifdef COUNTER_BCD2BIN_ERR_EN
    logic r_err;
    logic w_bcd_bad;

    always_comb begin
        w_bcd_bad = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            if (digit_is_invalid(bus.i_bcd[4*i +: 4])) begin
                w_bcd_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_bcd_bad;
        end
    end

    assign w_err = r_err;
`else
    assign w_err = 1'b0;
`endif

    assign bus.o_ready = w_ready;
    assign bus.o_valid = w_valid;
    assign bus.o_bin   = r_bin;
    assign bus.o_err   = w_err && (r_state == ST_DONE);

endmodule : counter_bcd2bin
`default_nettype wire

// File: tb/tb_counter_bcd2bin.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_bcd2bin
//  Description : Self-checking bench for counter_bcd2bin. Directed requests
//                push their expected result into a queue; an independent
//                monitor pops and compares on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_bcd2bin;
    localparam int N_DIG = 3;
    localparam int W_BIN = 10;

`ifdef COUNTER_BCD2BIN_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    typedef struct {
        logic [W_BIN-1:0] bin;
        logic             err;
        logic             chk_bin;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t sb_q[$];

    counter_bcd2bin_if #(.N_DIG(N_DIG), .W_BIN(W_BIN)) bus ();

    counter_bcd2bin #(.N_DIG(N_DIG), .W_BIN(W_BIN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares every accepted result against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_valid && bus.i_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got bin 0x%0h with empty scoreboard", bus.o_bin);
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk_bin) check("result_bin", 32'(bus.o_bin), 32'(e.bin));
                    check("result_err", 32'(bus.o_err), 32'(e.err));
                end
            end
        end
    end

    // Call at #1 after a rising edge. Waits for o_ready, issues one request.
    task automatic send(input logic [11:0] bcd, input logic [W_BIN-1:0] eb,
                        input logic ee, input logic cb, input logic push,
                        input logic chk_lat);
        int   guard;
        exp_t e;
        guard = 0;
        while (!bus.o_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_timeout", 32'(bus.o_ready), 32'd1);
        bus.i_valid = 1'b1;
        bus.i_bcd   = bcd;
        if (push) begin
            e.bin = eb; e.err = ee; e.chk_bin = cb;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_bcd   = 12'h3C5;     // garbage after accept must not matter
        if (chk_lat) begin
            repeat (W_BIN - 1) @(posedge clk);
            #1 check("valid_early", 32'(bus.o_valid), 32'd0);
            @(posedge clk); #1;
            check("valid_latency", 32'(bus.o_valid), 32'd1);
        end
    endtask

    initial begin
        int guard;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_bcd   = '0;
        bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_bin",   32'(bus.o_bin),   32'd0);
        check("rst_err",   32'(bus.o_err),   32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic conversions, consumer always ready.
        send(12'h000, 10'd0,   1'b0, 1'b1, 1'b1, 1'b1);
        send(12'h999, 10'h3E7, 1'b0, 1'b1, 1'b1, 1'b1);
        send(12'h255, 10'h0FF, 1'b0, 1'b1, 1'b1, 1'b0);
        send(12'h001, 10'd1,   1'b0, 1'b1, 1'b1, 1'b0);
        send(12'h512, 10'd512, 1'b0, 1'b1, 1'b1, 1'b0);
        send(12'h064, 10'd64,  1'b0, 1'b1, 1'b1, 1'b0);

        // Back-pressure: result must hold while i_ready is low.
        guard = 0;
        while (!bus.o_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        bus.i_ready = 1'b0;
        send(12'h128, 10'd128, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.o_valid), 32'd1);
            check("hold_bin",   32'(bus.o_bin),   32'd128);
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid", 32'(bus.o_valid), 32'd0);
        check("release_ready", 32'(bus.o_ready), 32'd1);
        check("release_bin",   32'(bus.o_bin),   32'd128);

        // Illegal digit, then a clean request clears the flag.
        send(12'h1A3, 10'd0,  ERR_ON, 1'b0, 1'b1, 1'b0);
        send(12'h042, 10'd42, 1'b0,   1'b1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a conversion.
        send(12'h500, 10'd500, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.o_ready), 32'd1);
        check("midrst_valid", 32'(bus.o_valid), 32'd0);
        check("midrst_bin",   32'(bus.o_bin),   32'd0);
        check("midrst_err",   32'(bus.o_err),   32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Request during CONV is ignored.
        send(12'h500, 10'd500, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus.i_valid = 1'b1;
        bus.i_bcd   = 12'h777;
        check("busy_ready", 32'(bus.o_ready), 32'd0);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        send(12'h777, 10'd777, 1'b0, 1'b1, 1'b1, 1'b0);

        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin @(posedge clk); guard++; end
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule : tb_counter_bcd2bin
`default_nettype wire

// File: doc/counter_bcd2bin.md
Name: counter_bcd2bin

Overview:
Sequential BCD-to-binary converter, the reverse direction of the counter's binary-to-BCD path. It turns N_DIG packed BCD digits (for example, a value typed in on the board switches for the counter preload) into a plain binary number. It uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from every digit that is 8 or more. A valid/ready handshake sits on both the input and output sides.

Parameters:
N_DIG, 3, number of BCD digits on i_bcd.
W_BIN, 10, output width and shift-cycle count; must satisfy 2^W_BIN >= 10^N_DIG.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_valid  input  1  i_bcd is valid; conversion request.
o_ready  output  1  block can accept a request; high only in IDLE.
i_bcd  input  4*N_DIG  packed BCD, digit 0 in [3:0].
o_valid  output  1  o_bin/o_err are valid; high only in DONE.
i_ready  input  1  consumer accepts the result.
o_bin  output  W_BIN  binary result.
o_err  output  1  at least one input digit was greater than 9 (see Optional Feature).

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; counter=0; BCD and binary shift registers=0.
  - o_ready=1, o_valid=0, o_bin=0, o_err=0.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready at an edge: capture i_bcd into the BCD register, clear the binary register and counter, latch the error flag, go to CONV.
- CONV, one iteration per cycle:
  - Shift {bcd_reg, bin_reg} right by 1 (bcd LSB enters bin MSB).
  - Then, in each shifted digit, if digit >= 8 subtract 3.
  - Increment the counter. After W_BIN iterations go to DONE.
- Timing: o_valid rises exactly W_BIN edges after the accepting edge (10 for the defaults).
  - Back-to-back throughput is W_BIN+2 cycles minimum.
- DONE:
  - o_valid=1; o_bin=bin_reg and o_err are held stable until i_ready=1 at an edge.
  - On that edge go to IDLE; o_valid falls, and o_bin keeps its last value.
- i_valid outside IDLE is ignored; there is no queueing.
- i_bcd is sampled only at the accepting edge; later changes have no effect.
- Arithmetic:
  - Per-digit correction is 4-bit unsigned.
  - Valid input keeps every digit < 13 before correction, so no underflow.
  - Counter width is clog2(W_BIN+1).
- Boundaries:
  - Input 0 gives 0.
  - Input all-9s gives 10^N_DIG-1 (999 = 10'h3E7 by default).
  - Result is exact for every valid input.
- Reset mid-CONV or mid-DONE: immediate return to reset values; the pending result is lost.
- i_ready held high in IDLE has no effect.

Optional Feature:
- Macro: COUNTER_BCD2BIN_ERR_EN.
- Defined:
  - At the accepting edge, any digit > 9 sets an err register; o_err presents it during DONE.
  - The conversion still runs; o_bin is unspecified when o_err=1.
  - err clears on the next accept and on reset.
- Undefined:
  - o_err is tied to 0 and there is no check logic.
  - Invalid digits produce unspecified o_bin; timing is identical.

Decomposition:
- Package counter_bcd2bin_pkg:
  - state enum (IDLE, CONV, DONE).
  - Default constants N_DIG=3 and W_BIN=10.
  - Correction constants CORR_THRESH=4'd8 and CORR_SUB=4'd3.
- One sub-module, counter_bcd_digit_corr: combinational 4-bit "if >= 8 subtract 3", instantiated N_DIG times in a generate loop.

Test Plan:
- i_bcd=12'h000, i_ready=1 -> o_valid rises 10 edges after accept, o_bin=10'd0, o_err=0.
- i_bcd=12'h999 -> o_bin=10'h3E7.
- i_bcd=12'h255 -> o_bin=10'h0FF.
- i_bcd=12'h128, i_ready held 0 for 5 cycles in DONE -> o_valid and o_bin=10'd128 stable for all 5 cycles.
  - i_ready=1 -> next cycle o_valid=0, o_ready=1.
- i_bcd=12'h1A3 with COUNTER_BCD2BIN_ERR_EN -> o_err=1 in DONE.
  - Next accept of 12'h042 -> o_err=0, o_bin=10'd42.
  - Without the macro -> o_err=0.
- Accept 12'h500, pulse i_rst_n low at iteration 4 -> outputs return to reset values asynchronously.
  - Pulse i_valid with 12'h777 during CONV -> ignored, result still 10'd500; after the handshake 12'h777 -> 10'd777.
